// File: rtl/logs_sequencer.sv
// Step sequencer: plays a STEPS-deep pattern of N-bit voice masks, one step per TEMPO clocks,
// and applies each mask to the voice gates only on a mixer frame boundary.
module logs_sequencer #(
    parameter int N     = 1,
    parameter int STEPS = 8,
    parameter int TW    = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     pat_we,
    input  logic [$clog2(STEPS)-1:0] pat_addr,
    input  logic [N-1:0]             pat_data,
    input  logic                     tempo_we,
    input  logic [TW-1:0]            tempo_in,
    input  logic                     loop,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     frame_tick,
    output logic [N-1:0]             voice_en,
    output logic [$clog2(STEPS)-1:0] step_idx,
    output logic                     step_stb,
    output logic                     busy
);

    localparam int AW = $clog2(STEPS);
    localparam logic [AW-1:0] LAST_IDX = AW'(STEPS - 1);
    localparam logic [TW-1:0] ONE_TW   = TW'(1'b1);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] step_idx_q, step_idx_d;
    logic [TW-1:0] count_q, count_d;
    logic [TW-1:0] tempo_q, tempo_d;
    logic [TW-1:0] step_len_q, step_len_d;
    logic [N-1:0]  pending_q, pending_d;
    logic [N-1:0]  voice_en_q, voice_en_d;
    logic          step_stb_q, step_stb_d;
    logic          busy_q, busy_d;
    logic [N-1:0]  pattern_q [STEPS];

    logic [TW-1:0] tempo_eff_s;
    logic [AW-1:0] step_nxt_s;
    logic          step_end_s;

    // Step length is latched at step entry, so a tempo write never stretches the step in progress.
    assign tempo_eff_s = (tempo_q == '0) ? ONE_TW : tempo_q;
    assign step_nxt_s  = step_idx_q + AW'(1'b1);
    assign step_end_s  = (count_q == (step_len_q - ONE_TW));

    // Pattern RAM write port; storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (pat_we) begin
            pattern_q[pat_addr] <= pat_data;
        end
    end

    // Next-state and datapath decode for the IDLE/PLAY sequencer.
    always_comb begin
        state_d    = state_q;
        step_idx_d = step_idx_q;
        count_d    = count_q;
        pending_d  = pending_q;
        voice_en_d = voice_en_q;
        step_len_d = step_len_q;
        step_stb_d = 1'b0;
        tempo_d    = tempo_we ? tempo_in : tempo_q;
        case (state_q)
            IDLE: begin
                voice_en_d = '0;
                if (stop) begin
                    step_idx_d = '0;
                end else if (start) begin
                    state_d    = PLAY;
                    step_idx_d = '0;
                    count_d    = '0;
                    pending_d  = pattern_q[0];
                    step_len_d = tempo_eff_s;
                end else begin
                    state_d = IDLE;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_d    = IDLE;
                    voice_en_d = '0;
                    step_idx_d = '0;
                    count_d    = '0;
                end else begin
                    // The mask applied here is the one pending before this edge.
                    if (frame_tick) begin
                        voice_en_d = pending_q;
                    end else begin
                        voice_en_d = voice_en_q;
                    end
                    if (start) begin
                        step_idx_d = '0;
                        count_d    = '0;
                        pending_d  = pattern_q[0];
                        step_len_d = tempo_eff_s;
                    end else if (step_end_s) begin
                        count_d    = '0;
                        step_stb_d = 1'b1;
                        step_len_d = tempo_eff_s;
                        if ((step_idx_q != LAST_IDX) || loop) begin
                            step_idx_d = step_nxt_s;
                            pending_d  = pattern_q[step_nxt_s];
                        end else begin
                            state_d    = IDLE;
                            voice_en_d = '0;
                            step_idx_d = '0;
                        end
                    end else begin
                        count_d = count_q + ONE_TW;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                voice_en_d = '0;
                step_idx_d = '0;
                count_d    = '0;
            end
        endcase
        busy_d = (state_d == PLAY);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            step_idx_q <= '0;
            count_q    <= '0;
            tempo_q    <= ONE_TW;
            step_len_q <= ONE_TW;
            pending_q  <= '0;
            voice_en_q <= '0;
            step_stb_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_idx_q <= step_idx_d;
            count_q    <= count_d;
            tempo_q    <= tempo_d;
            step_len_q <= step_len_d;
            pending_q  <= pending_d;
            voice_en_q <= voice_en_d;
            step_stb_q <= step_stb_d;
            busy_q     <= busy_d;
        end
    end

    assign voice_en = voice_en_q;
    assign step_idx = step_idx_q;
    assign step_stb = step_stb_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_logs_sequencer.sv
// Table-driven bench for logs_sequencer (N=2, STEPS=8, TW=16); expected outputs are queued
// as each vector is driven and compared one clock later.
module tb_logs_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        pat_we = 1'b0;
    logic [2:0]  pat_addr = 3'd0;
    logic [1:0]  pat_data = 2'd0;
    logic        tempo_we = 1'b0;
    logic [15:0] tempo_in = 16'd0;
    logic        loop = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        frame_tick = 1'b0;
    logic [1:0]  voice_en;
    logic [2:0]  step_idx;
    logic        step_stb;
    logic        busy;

    logs_sequencer #(.N(2), .STEPS(8), .TW(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .pat_we(pat_we), .pat_addr(pat_addr), .pat_data(pat_data),
        .tempo_we(tempo_we), .tempo_in(tempo_in), .loop(loop),
        .start(start), .stop(stop), .frame_tick(frame_tick),
        .voice_en(voice_en), .step_idx(step_idx), .step_stb(step_stb), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pw;
        logic [2:0]  pa;
        logic [1:0]  pd;
        logic        tw;
        logic [15:0] tv;
        logic        lp, st, sp, ft;
        logic [1:0]  ev;
        logic [2:0]  ei;
        logic        es, eb;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_err = 0;
    logic [1:0] pat [8];

    function automatic vec_t mk(logic st, logic sp, logic ft, logic lp,
                                logic [1:0] ev, logic [2:0] ei, logic es, logic eb);
        vec_t v;
        v.pw = 1'b0; v.pa = 3'd0; v.pd = 2'd0; v.tw = 1'b0; v.tv = 16'd0;
        v.st = st; v.sp = sp; v.ft = ft; v.lp = lp;
        v.ev = ev; v.ei = ei; v.es = es; v.eb = eb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one vector, queue its expectation, compare after the clock edge.
    task automatic apply(input vec_t v, input string nm, input int i);
        vec_t e;
        pat_we = v.pw; pat_addr = v.pa; pat_data = v.pd;
        tempo_we = v.tw; tempo_in = v.tv;
        loop = v.lp; start = v.st; stop = v.sp; frame_tick = v.ft;
        sb.push_back(v);
        @(posedge clk);
        #1;
        n_checks++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s[%0d]: scoreboard empty", nm, i);
        end else begin
            e = sb.pop_front();
            if ({voice_en, step_idx, step_stb, busy} !== {e.ev, e.ei, e.es, e.eb}) begin
                n_err++;
                $display("FAIL %s[%0d]: voice_en=%0d step_idx=%0d step_stb=%0d busy=%0d, expected %0d %0d %0d %0d",
                         nm, i, voice_en, step_idx, step_stb, busy, e.ev, e.ei, e.es, e.eb);
            end
        end
        pat_we = 1'b0; tempo_we = 1'b0; start = 1'b0; stop = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic run_tbl(input string nm);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], nm, i);
        end
        tbl.delete();
    endtask

    task automatic cfg_pat(input logic [2:0] a, input logic [1:0] d);
        vec_t v;
        v = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
        v.pw = 1'b1; v.pa = a; v.pd = d;
        apply(v, "cfg_pat", int'(a));
    endtask

    task automatic cfg_tempo(input logic [15:0] t);
        vec_t v;
        v = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
        v.tw = 1'b1; v.tv = t;
        apply(v, "cfg_tempo", int'(t));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [1:0] curv;
        int s, e;
        pat[0] = 2'd1; pat[1] = 2'd2; pat[2] = 2'd3; pat[3] = 2'd0;
        pat[4] = 2'd2; pat[5] = 2'd1; pat[6] = 2'd3; pat[7] = 2'd2;

        // Reset state
        #1 reset_n = 1'b0;
        #1 chk("reset_outputs", {2'b0, voice_en, step_idx, step_stb, busy}, 8'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            cfg_pat(3'(i), pat[i]);
        end

        // Loop playback, tempo 4, frame tick every cycle, through the 7->0 wrap
        cfg_tempo(16'd4);
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 3'd0, 1'b0, 1'b1));
        for (int k = 1; k <= 36; k++) begin
            tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, pat[((k - 1) / 4) % 8], 3'((k / 4) % 8),
                             (k % 4) == 0, 1'b1));
        end
        run_tbl("loop");

        // Asynchronous reset mid-play, checked before any further clock edge
        chk("pre_reset_busy", {7'b0, busy}, 8'd1);
        #2 reset_n = 1'b0;
        #1 chk("midplay_reset", {2'b0, voice_en, step_idx, step_stb, busy}, 8'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Frame gating: tempo 3, frame tick on cycles 4,12,20,28 (12 is a step boundary)
        cfg_tempo(16'd3);
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0, 1'b1));
        curv = 2'd0;
        for (int k = 1; k <= 30; k++) begin
            if ((k % 8) == 4) curv = pat[((k - 1) / 3) % 8];
            tbl.push_back(mk(1'b0, 1'b0, (k % 8) == 4, 1'b1, curv, 3'((k / 3) % 8),
                             (k % 3) == 0, 1'b1));
        end
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0));
        run_tbl("gating");

        // One-shot: loop=0, tempo 2 -> back to IDLE 16 cycles after busy rose
        cfg_tempo(16'd2);
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1));
        for (int k = 1; k <= 15; k++) begin
            tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, pat[(k - 1) / 2], 3'(k / 2),
                             (k % 2) == 0, 1'b1));
        end
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0));
        run_tbl("oneshot");

        // Controls: start+stop stays IDLE; tempo 0 = one step per clock; restart at step 5
        cfg_tempo(16'd0);
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd1, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd2, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 3'd3, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 3'd4, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 3'd5, 1'b1, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 3'd0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 3'd1, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 3'd2, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0));
        run_tbl("controls");

        // Live pattern edit: pattern[2] rewritten to 1 while step 2 plays
        cfg_tempo(16'd4);
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 3'd0, 1'b0, 1'b1));
        for (int k = 1; k <= 44; k++) begin
            s = ((k - 1) / 4) % 8;
            e = 4 * ((k - 1) / 4);
            v = mk(1'b0, 1'b0, 1'b1, 1'b1, (s == 2 && e > 9) ? 2'd1 : pat[s], 3'((k / 4) % 8),
                   (k % 4) == 0, 1'b1);
            if (k == 9) begin
                v.pw = 1'b1; v.pa = 3'd2; v.pd = 2'd1;
            end
            tbl.push_back(v);
        end
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0));
        run_tbl("live_pat");
        cfg_pat(3'd2, pat[2]);

        // Live tempo edit: write tempo 2 during step 0 of a tempo-4 run
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0, 1'b1));
        v = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0, 1'b1);
        v.tw = 1'b1; v.tv = 16'd2;
        tbl.push_back(v);
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd1, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd2, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd2, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd3, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0));
        run_tbl("live_tempo");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
